// File: rtl/sm_input_filter_pkg.sv
// Shared configuration for the sm_input_filter block: top-level defaults
// and a helper that sizes the prescaler counter.
package sm_input_filter_pkg;

  // Board-level defaults for the input filter.
  localparam int SM_CONFIG_FILTER_PRESCALE = 1;
  localparam int SM_CONFIG_FILTER_STABLE   = 3;

  // Prescaler counter width; a PRESCALE of 1 still needs one bit.
  function automatic int pcntWidth(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/sm_input_filter_if.sv
// Signal bundle between the board pins/core logic and sm_input_filter.
// All signals are plain levels sampled on clk; there is no valid/ready
// handshake: d is captured every clock, q is a level, and rise/fall/changed
// are single-cycle pulses that the consumer must sample on every clock.
interface sm_input_filter_if #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 4
);
  logic                 enable;
  logic [CNT_WIDTH-1:0] stableCnt;
  logic [WIDTH-1:0]     d;
  logic [WIDTH-1:0]     q;
  logic [WIDTH-1:0]     rise;
  logic [WIDTH-1:0]     fall;
  logic                 changed;

  // Drives the raw inputs and configuration, consumes filtered results.
  modport master (
    output enable, stableCnt, d,
    input  q, rise, fall, changed
  );

  // The filter itself.
  modport slave (
    input  enable, stableCnt, d,
    output q, rise, fall, changed
  );
endinterface

// File: rtl/sm_filter_channel.sv
// One filter channel: SYNC_STAGES-deep synchronizer, stability counter,
// filtered level q and registered rise/fall pulses. Tick and stableCnt are
// shared from the parent.
module sm_filter_channel import sm_input_filter_pkg::*; #(
  parameter int   SYNC_STAGES = 2,
  parameter int   CNT_WIDTH   = 4,
  parameter logic RESET_BIT   = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic [CNT_WIDTH-1:0] stableCnt,
  input  logic                 d,
  output logic                 q,
  output logic                 rise,
  output logic                 fall,
  output logic                 flip
);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_WIDTH-1:0]   cnt;
  logic                   s;
  logic [CNT_WIDTH:0]     neff;
  logic [CNT_WIDTH:0]     cntInc;

  assign s = sync[SYNC_STAGES-1];

  // Zero required ticks behaves as one; one extra bit keeps cnt+1 from wrapping.
  always_comb begin
    neff   = (stableCnt == '0) ? {{CNT_WIDTH{1'b0}}, 1'b1} : {1'b0, stableCnt};
    cntInc = {1'b0, cnt} + {{CNT_WIDTH{1'b0}}, 1'b1};
    flip   = (s != q) && tick && (cntInc >= neff);
  end

  // Synchronizer runs every clock; counter/q advance only on ticks, but a
  // reversion to q clears the counter at any time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= {SYNC_STAGES{RESET_BIT}};
      q    <= RESET_BIT;
      cnt  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d};
      rise <= 1'b0;
      fall <= 1'b0;
      if (s == q) begin
        cnt <= '0;
      end else if (flip) begin
        q    <= s;
        cnt  <= '0;
        rise <= s;
        fall <= ~s;
      end else if (tick) begin
        cnt <= cntInc[CNT_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/sm_input_filter.sv
// Multi-channel input conditioner: holds the shared prescaler and the
// aggregate changed flag, and instantiates one sm_filter_channel per input.
module sm_input_filter import sm_input_filter_pkg::*; #(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter int               CNT_WIDTH   = 4,
  parameter int               PRESCALE    = SM_CONFIG_FILTER_PRESCALE,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input logic               clk,
  input logic               rst,
  sm_input_filter_if.slave  io
);

  localparam int PW = pcntWidth(PRESCALE);

  logic [PW-1:0]    pcnt;
  logic             tick;
  logic [WIDTH-1:0] qVec;
  logic [WIDTH-1:0] riseVec;
  logic [WIDTH-1:0] fallVec;
  logic [WIDTH-1:0] flipVec;
  logic             changedReg;

  assign tick = io.enable && (pcnt == PW'(PRESCALE - 1));

  // Prescaler: counts only while enabled, wraps on the tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
    end else if (io.enable) begin
      pcnt <= tick ? '0 : pcnt + 1'b1;
    end
  end

  // changed is registered from the same condition that sets rise/fall,
  // so it lines up with the pulses cycle for cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      changedReg <= 1'b0;
    end else begin
      changedReg <= |flipVec;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    sm_filter_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_WIDTH   (CNT_WIDTH),
      .RESET_BIT   (RESET_VALUE[i])
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .stableCnt (io.stableCnt),
      .d         (io.d[i]),
      .q         (qVec[i]),
      .rise      (riseVec[i]),
      .fall      (fallVec[i]),
      .flip      (flipVec[i])
    );
  end

  assign io.q       = qVec;
  assign io.rise    = riseVec;
  assign io.fall    = fallVec;
  assign io.changed = changedReg;

endmodule

// File: tb/tb_sm_input_filter.sv
// Directed testbench for sm_input_filter using three instances:
// A (8 ch, prescale 1), B (4 ch, prescale 5), C (8 ch, reset value A5).
module tb_sm_input_filter;
  import sm_input_filter_pkg::*;

  logic clk;
  logic rst;
  logic rstC;
  int   tests_run;
  int   tests_failed;

  sm_input_filter_if #(.WIDTH(8), .CNT_WIDTH(4)) ifA ();
  sm_input_filter_if #(.WIDTH(4), .CNT_WIDTH(4)) ifB ();
  sm_input_filter_if #(.WIDTH(8), .CNT_WIDTH(4)) ifC ();

  sm_input_filter #(.WIDTH(8), .SYNC_STAGES(2), .CNT_WIDTH(4), .PRESCALE(1),
    .RESET_VALUE(8'h00)) dutA (.clk(clk), .rst(rst), .io(ifA));
  sm_input_filter #(.WIDTH(4), .SYNC_STAGES(2), .CNT_WIDTH(4), .PRESCALE(5),
    .RESET_VALUE(4'h0)) dutB (.clk(clk), .rst(rst), .io(ifB));
  sm_input_filter #(.WIDTH(8), .SYNC_STAGES(2), .CNT_WIDTH(4), .PRESCALE(1),
    .RESET_VALUE(8'hA5)) dutC (.clk(clk), .rst(rstC), .io(ifC));

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; return 1 time unit after the edge for sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    tests_run++;
    if (ifA.q !== 8'h00 || ifA.rise !== 8'h00 || ifA.fall !== 8'h00 || ifA.changed !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_A: q=%h rise=%h fall=%h chg=%b want 00/00/00/0", ifA.q, ifA.rise, ifA.fall, ifA.changed);
    end
    tests_run++;
    if (ifB.q !== 4'h0) begin
      tests_failed++;
      $display("FAIL reset_B: q=%h want 0", ifB.q);
    end
    tests_run++;
    if (ifC.q !== 8'hA5 || ifC.rise !== 8'h00 || ifC.fall !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_C: q=%h rise=%h fall=%h want A5/00/00", ifC.q, ifC.rise, ifC.fall);
    end
    rst = 1'b0;
    rstC = 1'b0;
    step();
    step();
    tests_run++;
    if (ifA.changed !== 1'b0 || ifC.rise !== 8'h00 || ifC.fall !== 8'h00 || ifC.q !== 8'hA5) begin
      tests_failed++;
      $display("FAIL reset_release: A chg=%b C q=%h rise=%h fall=%h want 0/A5/00/00", ifA.changed, ifC.q, ifC.rise, ifC.fall);
    end
  endtask

  task automatic test_latency();
    ifA.stableCnt = 4'd3;
    ifA.d = 8'h01;
    repeat (4) step();
    tests_run++;
    if (ifA.q !== 8'h00 || ifA.rise !== 8'h00) begin
      tests_failed++;
      $display("FAIL latency_early: q=%h rise=%h want 00/00", ifA.q, ifA.rise);
    end
    step();
    tests_run++;
    if (ifA.q !== 8'h01 || ifA.rise !== 8'h01 || ifA.fall !== 8'h00 || ifA.changed !== 1'b1) begin
      tests_failed++;
      $display("FAIL latency_edge5: q=%h rise=%h fall=%h chg=%b want 01/01/00/1", ifA.q, ifA.rise, ifA.fall, ifA.changed);
    end
    step();
    tests_run++;
    if (ifA.q !== 8'h01 || ifA.rise !== 8'h00 || ifA.changed !== 1'b0) begin
      tests_failed++;
      $display("FAIL latency_pulse_end: q=%h rise=%h chg=%b want 01/00/0", ifA.q, ifA.rise, ifA.changed);
    end
  endtask

  task automatic test_bounce();
    int riseCount;
    logic glitchBad;
    riseCount = 0;
    glitchBad = 1'b0;
    ifA.stableCnt = 4'd4;
    for (int k = 0; k < 4; k++) begin
      ifA.d = (k % 2 == 0) ? 8'h03 : 8'h01;
      repeat (2) begin
        step();
        if (ifA.q[1] !== 1'b0) glitchBad = 1'b1;
        if (ifA.rise[1] === 1'b1) riseCount++;
      end
    end
    tests_run++;
    if (glitchBad !== 1'b0) begin
      tests_failed++;
      $display("FAIL bounce_glitch: q[1] went high during glitches, want 0");
    end
    ifA.d = 8'h03;
    repeat (5) begin
      step();
      if (ifA.rise[1] === 1'b1) riseCount++;
    end
    tests_run++;
    if (ifA.q !== 8'h01) begin
      tests_failed++;
      $display("FAIL bounce_edge5: q=%h want 01", ifA.q);
    end
    step();
    if (ifA.rise[1] === 1'b1) riseCount++;
    tests_run++;
    if (ifA.q !== 8'h03 || ifA.rise !== 8'h02) begin
      tests_failed++;
      $display("FAIL bounce_edge6: q=%h rise=%h want 03/02", ifA.q, ifA.rise);
    end
    repeat (4) begin
      step();
      if (ifA.rise[1] === 1'b1) riseCount++;
    end
    tests_run++;
    if (riseCount !== 1) begin
      tests_failed++;
      $display("FAIL bounce_pulse_count: got %0d rise pulses want 1", riseCount);
    end
  endtask

  task automatic test_stable_edges();
    ifA.stableCnt = 4'd0;
    ifA.d = 8'h07;
    repeat (2) step();
    tests_run++;
    if (ifA.q !== 8'h03) begin
      tests_failed++;
      $display("FAIL stable0_early: q=%h want 03", ifA.q);
    end
    step();
    tests_run++;
    if (ifA.q !== 8'h07 || ifA.rise !== 8'h04) begin
      tests_failed++;
      $display("FAIL stable0_edge3: q=%h rise=%h want 07/04", ifA.q, ifA.rise);
    end
    repeat (3) step();
    ifA.stableCnt = 4'd15;
    ifA.d = 8'h03;
    repeat (16) step();
    tests_run++;
    if (ifA.q !== 8'h07 || ifA.fall !== 8'h00) begin
      tests_failed++;
      $display("FAIL stable15_edge16: q=%h fall=%h want 07/00", ifA.q, ifA.fall);
    end
    step();
    tests_run++;
    if (ifA.q !== 8'h03 || ifA.fall !== 8'h04 || ifA.changed !== 1'b1) begin
      tests_failed++;
      $display("FAIL stable15_edge17: q=%h fall=%h chg=%b want 03/04/1", ifA.q, ifA.fall, ifA.changed);
    end
  endtask

  task automatic test_multi_channel();
    ifA.stableCnt = 4'd2;
    ifA.d = 8'h00;
    repeat (8) step();
    tests_run++;
    if (ifA.q !== 8'h00 || ifA.changed !== 1'b0) begin
      tests_failed++;
      $display("FAIL multi_settle: q=%h chg=%b want 00/0", ifA.q, ifA.changed);
    end
    ifA.d = 8'hFF;
    repeat (3) step();
    tests_run++;
    if (ifA.q !== 8'h00) begin
      tests_failed++;
      $display("FAIL multi_rise_early: q=%h want 00", ifA.q);
    end
    step();
    tests_run++;
    if (ifA.q !== 8'hFF || ifA.rise !== 8'hFF || ifA.fall !== 8'h00 || ifA.changed !== 1'b1) begin
      tests_failed++;
      $display("FAIL multi_rise: q=%h rise=%h fall=%h chg=%b want FF/FF/00/1", ifA.q, ifA.rise, ifA.fall, ifA.changed);
    end
    ifA.d = 8'h00;
    repeat (4) step();
    tests_run++;
    if (ifA.q !== 8'h00 || ifA.fall !== 8'hFF || ifA.rise !== 8'h00 || ifA.changed !== 1'b1) begin
      tests_failed++;
      $display("FAIL multi_fall: q=%h rise=%h fall=%h chg=%b want 00/00/FF/1", ifA.q, ifA.rise, ifA.fall, ifA.changed);
    end
  endtask

  task automatic test_prescale();
    ifB.stableCnt = 4'd2;
    ifB.d = 4'b0100;
    ifB.enable = 1'b1;
    repeat (9) step();
    tests_run++;
    if (ifB.q !== 4'h0) begin
      tests_failed++;
      $display("FAIL prescale_edge9: q=%h want 0", ifB.q);
    end
    step();
    tests_run++;
    if (ifB.q !== 4'h4 || ifB.rise !== 4'h4 || ifB.changed !== 1'b1) begin
      tests_failed++;
      $display("FAIL prescale_edge10: q=%h rise=%h chg=%b want 4/4/1", ifB.q, ifB.rise, ifB.changed);
    end
    ifB.d = 4'b0000;
    repeat (5) step();
    ifB.enable = 1'b0;
    repeat (20) step();
    tests_run++;
    if (ifB.q !== 4'h4 || ifB.fall !== 4'h0 || ifB.rise !== 4'h0) begin
      tests_failed++;
      $display("FAIL prescale_frozen: q=%h rise=%h fall=%h want 4/0/0", ifB.q, ifB.rise, ifB.fall);
    end
    ifB.enable = 1'b1;
    repeat (4) step();
    tests_run++;
    if (ifB.q !== 4'h4) begin
      tests_failed++;
      $display("FAIL prescale_resume_early: q=%h want 4", ifB.q);
    end
    step();
    tests_run++;
    if (ifB.q !== 4'h0 || ifB.fall !== 4'h4 || ifB.changed !== 1'b1) begin
      tests_failed++;
      $display("FAIL prescale_resume: q=%h fall=%h chg=%b want 0/4/1", ifB.q, ifB.fall, ifB.changed);
    end
    step();
    tests_run++;
    if (ifB.fall !== 4'h0 || ifB.changed !== 1'b0) begin
      tests_failed++;
      $display("FAIL prescale_pulse_end: fall=%h chg=%b want 0/0", ifB.fall, ifB.changed);
    end
  endtask

  task automatic test_reset_midop();
    logic eventSeen;
    eventSeen = 1'b0;
    ifC.stableCnt = 4'd3;
    ifC.d = 8'h5A;
    repeat (3) step();
    tests_run++;
    if (ifC.q !== 8'hA5) begin
      tests_failed++;
      $display("FAIL midop_before_rst: q=%h want A5", ifC.q);
    end
    #2;
    rstC = 1'b1;
    #1;
    tests_run++;
    if (ifC.q !== 8'hA5 || ifC.rise !== 8'h00 || ifC.fall !== 8'h00 || ifC.changed !== 1'b0) begin
      tests_failed++;
      $display("FAIL midop_async_rst: q=%h rise=%h fall=%h chg=%b want A5/00/00/0", ifC.q, ifC.rise, ifC.fall, ifC.changed);
    end
    step();
    ifC.d = 8'hA5;
    rstC = 1'b0;
    repeat (10) begin
      step();
      if (ifC.rise !== 8'h00 || ifC.fall !== 8'h00 || ifC.changed !== 1'b0 || ifC.q !== 8'hA5)
        eventSeen = 1'b1;
    end
    tests_run++;
    if (eventSeen !== 1'b0) begin
      tests_failed++;
      $display("FAIL midop_after_release: event or q change seen, q=%h want A5 and no pulses", ifC.q);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1;
    rstC = 1'b1;
    ifA.enable = 1'b1;
    ifA.stableCnt = 4'(SM_CONFIG_FILTER_STABLE);
    ifA.d = 8'h00;
    ifB.enable = 1'b0;
    ifB.stableCnt = 4'd2;
    ifB.d = 4'h0;
    ifC.enable = 1'b1;
    ifC.stableCnt = 4'd3;
    ifC.d = 8'hA5;

    test_reset();
    test_latency();
    test_bounce();
    test_stable_edges();
    test_multi_channel();
    test_prescale();
    test_reset_midop();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
